// File: rtl/conv_puncturer.sv
// rtl/conv_puncturer.sv - punctures rate-1/2 coded pairs to 1/2, 2/3 or 3/4 and serialises kept bits through a bit FIFO
// Optional PUNCT_STATS_EN adds accepted-pair and punctured-bit counters.
module conv_puncturer #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_pair,
   input  logic       in_sop,
   input  logic [1:0] rate_sel,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_bit
`ifdef PUNCT_STATS_EN
   ,
   output logic [31:0] pairs_in_cnt,
   output logic [31:0] bits_drop_cnt
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [DEPTH-1:0] fifo_q;
   logic [DEPTH-1:0] fifo_n;
   logic [CW-1:0]    count;
   logic [CW-1:0]    cnt_s;
   logic [CW-1:0]    cnt_s1;
   logic [CW-1:0]    count_n;
   logic [1:0]       phase;
   logic [1:0]       rate_q;
   logic             last_bit;

   logic       accept;
   logic       pop;
   logic [1:0] eff_rate;
   logic [1:0] eff_phase;
   logic [1:0] phase_n;
   logic       keep_a;
   logic       keep_b;
   logic       period_end;
   logic [1:0] n_push;
   logic       push_b0;
   logic       push_b1;

   assign in_ready  = !rst && (count <= CW'(DEPTH - 2));
   assign out_valid = (count != '0);
   assign out_bit   = out_valid ? fifo_q[0] : last_bit;
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Rate only changes at a period boundary or on a frame start; otherwise the latched rate finishes its period.
   always_comb begin
      eff_rate   = rate_q;
      eff_phase  = phase;
      keep_a     = 1'b1;
      keep_b     = 1'b1;
      period_end = 1'b1;
      if (in_sop || phase == 2'd0)
         eff_rate = (rate_sel == 2'b11) ? 2'b00 : rate_sel;
      if (in_sop)
         eff_phase = 2'd0;
      case (eff_rate)
         2'b01: begin
            keep_b     = (eff_phase == 2'd0);
            period_end = (eff_phase == 2'd1);
         end
         2'b10: begin
            keep_a     = (eff_phase != 2'd2);
            keep_b     = (eff_phase != 2'd1);
            period_end = (eff_phase == 2'd2);
         end
         default: ;
      endcase
      phase_n = period_end ? 2'd0 : eff_phase + 2'd1;
   end

   // FIFO is a shift register with the head at bit 0; kept bits land just above the post-pop fill level.
   always_comb begin
      n_push  = accept ? ({1'b0, keep_a} + {1'b0, keep_b}) : 2'd0;
      push_b0 = keep_a ? in_pair[1] : in_pair[0];
      push_b1 = in_pair[0];
      fifo_n  = pop ? (fifo_q >> 1) : fifo_q;
      cnt_s   = count - CW'(pop);
      cnt_s1  = cnt_s + CW'(1);
      for (int i = 0; i < DEPTH; i++) begin
         if (n_push != 2'd0 && CW'(i) == cnt_s)
            fifo_n[i] = push_b0;
         if (n_push == 2'd2 && CW'(i) == cnt_s1)
            fifo_n[i] = push_b1;
      end
      count_n = cnt_s + CW'(n_push);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_q   <= '0;
         count    <= '0;
         phase    <= 2'd0;
         rate_q   <= 2'b00;
         last_bit <= 1'b0;
      end else begin
         fifo_q <= fifo_n;
         count  <= count_n;
         if (out_valid)
            last_bit <= fifo_q[0];
         if (accept) begin
            phase  <= phase_n;
            rate_q <= eff_rate;
         end
      end
   end

`ifdef PUNCT_STATS_EN
   logic [31:0] drop_now;

   assign drop_now = 32'd2 - 32'(n_push);

   always_ff @(posedge clk) begin
      if (rst) begin
         pairs_in_cnt  <= '0;
         bits_drop_cnt <= '0;
      end else if (accept) begin
         if (in_sop) begin
            pairs_in_cnt  <= 32'd1;
            bits_drop_cnt <= drop_now;
         end else begin
            pairs_in_cnt  <= pairs_in_cnt + 32'd1;
            bits_drop_cnt <= bits_drop_cnt + drop_now;
         end
      end
   end
`endif

endmodule

// File: tb/tb_conv_puncturer.sv
// tb/tb_conv_puncturer.sv - directed and randomized checks of conv_puncturer against a pattern-table model
module tb_conv_puncturer;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_pair;
   logic       in_sop;
   logic [1:0] rate_sel;
   logic       out_valid;
   logic       out_ready;
   logic       out_bit;
`ifdef PUNCT_STATS_EN
   logic [31:0] pairs_in_cnt;
   logic [31:0] bits_drop_cnt;
`endif

   conv_puncturer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pair   (in_pair),
      .in_sop    (in_sop),
      .rate_sel  (rate_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bit   (out_bit)
`ifdef PUNCT_STATS_EN
      ,
      .pairs_in_cnt  (pairs_in_cnt),
      .bits_drop_cnt (bits_drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: puncture tables indexed [rate][phase], period lengths, and a bit queue.
   bit          pat_a [3][3] = '{'{1, 0, 0}, '{1, 1, 0}, '{1, 1, 0}};
   bit          pat_b [3][3] = '{'{1, 0, 0}, '{1, 0, 0}, '{1, 0, 1}};
   int          period [3]   = '{1, 2, 3};
   bit          mq [$];
   int          mphase = 0;
   int          mrate  = 0;
   bit          mlast  = 0;
   int unsigned m_pairs = 0;
   int unsigned m_drop  = 0;
   bit          dummy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock: drive inputs, check outputs at negedge, advance the model at posedge.
   task automatic step(input bit v, input bit [1:0] p, input bit s, input bit [1:0] r,
                       input bit ordy, input bit rr, output bit acc);
      bit exp_rdy;
      bit pop;
      int ph;
      int kept;
      in_valid  = v;
      in_pair   = p;
      in_sop    = s;
      rate_sel  = r;
      out_ready = ordy;
      rst       = rr;
      @(negedge clk);
      exp_rdy = !rr && ((DEPTH - mq.size()) >= 2);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, mq.size() != 0);
      chk("out_bit", out_bit, (mq.size() != 0) ? mq[0] : mlast);
`ifdef PUNCT_STATS_EN
      chk("pairs_in_cnt", pairs_in_cnt, m_pairs);
      chk("bits_drop_cnt", bits_drop_cnt, m_drop);
`endif
      acc = v && exp_rdy;
      pop = (mq.size() != 0) && ordy;
      @(posedge clk);
      if (rr) begin
         mq.delete();
         mphase  = 0;
         mrate   = 0;
         mlast   = 0;
         m_pairs = 0;
         m_drop  = 0;
      end else begin
         if (pop)
            mlast = mq.pop_front();
         if (acc) begin
            if (s || mphase == 0)
               mrate = (r == 2'b11) ? 0 : int'(r);
            ph   = s ? 0 : mphase;
            kept = 0;
            if (pat_a[mrate][ph]) begin mq.push_back(p[1]); kept++; end
            if (pat_b[mrate][ph]) begin mq.push_back(p[0]); kept++; end
            mphase = (ph + 1) % period[mrate];
            if (s) begin
               m_pairs = 1;
               m_drop  = 2 - kept;
            end else begin
               m_pairs++;
               m_drop += 2 - kept;
            end
         end
      end
      #1;
   endtask

   task automatic send(input bit [1:0] p, input bit s, input bit [1:0] r);
      bit acc;
      int tries;
      acc   = 0;
      tries = 0;
      while (!acc && tries < 40) begin
         step(1'b1, p, s, r, 1'b1, 1'b0, acc);
         tries++;
      end
      if (!acc)
         chk("send_timeout", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (mq.size() != 0 && guard < 64) begin
         step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, dummy);
         guard++;
      end
      chk("drain_empty", 32'(mq.size()), 32'd0);
   endtask

   initial begin
      int nacc;
      bit acc;
      in_valid = 0; in_pair = 0; in_sop = 0; rate_sel = 0; out_ready = 0; rst = 1;

      // Reset state
      step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, dummy);
      step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, dummy);
      step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, dummy);
      chk("reset_out_bit", out_bit, 1'b0);

      // Rate 1/2: 10,01,11 -> 1,0,0,1,1,1
      send(2'b10, 1'b1, 2'b00);
      send(2'b01, 1'b0, 2'b00);
      send(2'b11, 1'b0, 2'b00);
      drain();

      // Rate 2/3 with sop: 11,10 -> 1,1,1
      send(2'b11, 1'b1, 2'b01);
      send(2'b10, 1'b0, 2'b01);
      drain();
      chk("r23_phase_wrap", 32'(mphase), 32'd0);

      // Rate 3/4: 10,01,11 -> 1,0,0,1 ; stats 3 pairs, 2 dropped
      send(2'b10, 1'b1, 2'b10);
      send(2'b01, 1'b0, 2'b10);
      send(2'b11, 1'b0, 2'b10);
      drain();

      // Full FIFO: out_ready held low, exactly 4 rate-1/2 pairs accepted
      nacc = 0;
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 2'(i), (i == 0), 2'b00, 1'b0, 1'b0, acc);
         if (acc) nacc++;
      end
      chk("full_accepts", 32'(nacc), 32'd4);
      drain();

      // Mid-period rate change is deferred; sop at phase 1 restarts
      send(2'b11, 1'b1, 2'b10);
      send(2'b10, 1'b0, 2'b00);
      send(2'b01, 1'b0, 2'b00);
      send(2'b11, 1'b0, 2'b00);
      send(2'b11, 1'b0, 2'b10);
      send(2'b01, 1'b1, 2'b10);
      drain();

      // Reset with bits queued: nothing stale afterwards
      for (int i = 0; i < 3; i++)
         step(1'b1, 2'b11, (i == 0), 2'b10, 1'b0, 1'b0, dummy);
      step(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, dummy);
      step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, dummy);
      for (int i = 0; i < 3; i++)
         step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, dummy);

      // Randomized traffic
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 9) == 0),
              2'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0, dummy);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
